// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared types and constants for the codec configuration sequencer
// Purpose: FSM state encoding, codec register addresses, boot table entry type
//          and table indexing constants used by the sequencer and its interface.
// Ports:   none (package).
package codec_cfg_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_GAP,
    S_SETTLE,
    S_READY,
    S_FAIL
  } state_t;

  localparam logic [ADDR_W-1:0] R0  = 7'd0;
  localparam logic [ADDR_W-1:0] R1  = 7'd1;
  localparam logic [ADDR_W-1:0] R4  = 7'd4;
  localparam logic [ADDR_W-1:0] R6  = 7'd6;
  localparam logic [ADDR_W-1:0] R7  = 7'd7;
  localparam logic [ADDR_W-1:0] R9  = 7'd9;
  localparam logic [ADDR_W-1:0] R15 = 7'd15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Six power-up entries (0..5) followed by the activate write at index 6.
  localparam logic [3:0] TABLE_LEN      = 4'd6;
  localparam logic [3:0] LAST_TABLE_IDX = TABLE_LEN - 4'd1;
  localparam logic [3:0] ACT_INDEX      = TABLE_LEN;
  localparam logic [3:0] HOST_INDEX     = 4'd15;

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// rtl/codec_cfg_sequencer_if.sv - I2C master request/status bundle
// Purpose: groups the write request to the I2C master and its returned status.
// Ports:   master modport (sequencer): drives i2c_register/i2c_din/i2c_enable/i2c_rw,
//          samples i2c_rdy/i2c_err. slave modport (I2C master): the reverse.
interface codec_cfg_sequencer_if;
  import codec_cfg_pkg::*;

  logic [ADDR_W-1:0] i2c_register;
  logic [DATA_W-1:0] i2c_din;
  logic              i2c_enable;
  logic              i2c_rw;
  logic              i2c_rdy;
  logic              i2c_err;

  modport master (
    output i2c_register, i2c_din, i2c_enable, i2c_rw,
    input  i2c_rdy, i2c_err
  );

  modport slave (
    input  i2c_register, i2c_din, i2c_enable, i2c_rw,
    output i2c_rdy, i2c_err
  );

endinterface

// File: rtl/codec_cfg_sequencer_sync2.sv
// rtl/codec_cfg_sequencer_sync2.sv - two-flop level synchronizer
// Purpose: brings a level from the I2C master clock domain into clk.
// Ports:   clk, reset (sync, active-high), d (async level in), q (synchronized out).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - codec boot sequencer and host write arbiter
// Purpose: replays the power-up write table to the I2C master, waits the settle
//          delay, writes the activate register, enables audio, then serves single
//          host register writes with retry/timeout and failure reporting.
// Ports:   clk, reset (sync, active-high), start (boot request pulse),
//          i2c (master modport to the I2C master), host_req/host_addr/host_data/host_ack
//          (host write handshake), busy/done/error/fail_index/audio_en (status).
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter logic [23:0] ACT_DELAY      = 24'h0FFFFF,
  parameter logic [15:0] GAP_CYCLES     = 16'd256,
  parameter int unsigned MAX_RETRY      = 2,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  codec_cfg_sequencer_if.master i2c,
  input  logic                  host_req,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_data,
  output logic                  host_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [3:0]            fail_index,
  output logic                  audio_en
);

  localparam logic [23:0] TMO_LAST  = {4'd0, TIMEOUT_CYCLES} - 24'd1;
  localparam logic [23:0] GAP_LAST  = {8'd0, GAP_CYCLES} - 24'd1;
  localparam logic [23:0] ACT_LAST  = ACT_DELAY - 24'd1;
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  logic rdy_s, err_s;

  sync2 u_sync_rdy (.clk(clk), .reset(reset), .d(i2c.i2c_rdy), .q(rdy_s));
  sync2 u_sync_err (.clk(clk), .reset(reset), .d(i2c.i2c_err), .q(err_s));

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        retry_q, retry_d;
  logic [23:0]       cnt_q, cnt_d;
  logic              ok_q, ok_d;
  logic              host_q, host_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hdata_q, hdata_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [3:0]        fidx_q, fidx_d;
  logic              aen_q, aen_d;
  logic              ack_q, ack_d;
  logic              do_boot;
  entry_t            rom_entry;

  always_comb begin
    rom_entry = '{addr: R9, data: 9'h001};
    case (idx_q)
      4'd0:    rom_entry = '{addr: R15, data: 9'h000};
      4'd1:    rom_entry = '{addr: R6,  data: 9'h000};
      4'd2:    rom_entry = '{addr: R0,  data: 9'h017};
      4'd3:    rom_entry = '{addr: R1,  data: 9'h017};
      4'd4:    rom_entry = '{addr: R4,  data: 9'h002};
      4'd5:    rom_entry = '{addr: R7,  data: 9'h04A};
      default: rom_entry = '{addr: R9,  data: 9'h001};
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    host_d  = host_q;
    haddr_d = haddr_q;
    hdata_d = hdata_q;
    reg_d   = reg_q;
    din_d   = din_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    fidx_d  = fidx_q;
    aen_d   = aen_q;
    ack_d   = 1'b0;
    do_boot = 1'b0;

    case (state_q)
      // Only reachable from reset, so it boots unconditionally.
      S_IDLE: do_boot = 1'b1;
      S_ISSUE: begin
        reg_d   = host_q ? haddr_q : rom_entry.addr;
        din_d   = host_q ? hdata_q : rom_entry.data;
        en_d    = 1'b1;
        cnt_d   = 24'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 24'd1;
        if (rdy_s) begin
          ok_d    = 1'b1;
          en_d    = 1'b0;
          state_d = S_RELEASE;
        end else if (err_s || cnt_q == TMO_LAST) begin
          ok_d    = 1'b0;
          en_d    = 1'b0;
          state_d = S_RELEASE;
        end
      end
      // Hold off until the master has withdrawn its status.
      S_RELEASE: begin
        if (!rdy_s && !err_s) begin
          cnt_d   = 24'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 24'd0;
          if (ok_q) begin
            if (host_q) begin
              ack_d   = 1'b1;
              busy_d  = 1'b0;
              if (haddr_q == R9) aen_d = hdata_q[0];
              state_d = S_READY;
            end else if (idx_q == LAST_TABLE_IDX) begin
              state_d = S_SETTLE;
            end else if (idx_q == ACT_INDEX) begin
              aen_d   = 1'b1;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_READY;
            end else begin
              idx_d   = idx_q + 4'd1;
              retry_d = 4'd0;
              state_d = S_ISSUE;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_ISSUE;
          end else begin
            error_d = 1'b1;
            aen_d   = 1'b0;
            busy_d  = 1'b0;
            if (host_q) begin
              fidx_d  = HOST_INDEX;
              ack_d   = 1'b1;
              state_d = S_READY;
            end else begin
              fidx_d  = idx_q;
              state_d = S_FAIL;
            end
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == ACT_LAST) begin
          idx_d   = ACT_INDEX;
          retry_d = 4'd0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_READY: begin
        // ack_q guard: the host still holds req in the cycle the ack is visible.
        if (start) begin
          do_boot = 1'b1;
        end else if (host_req && !ack_q) begin
          haddr_d = host_addr;
          hdata_d = host_data;
          host_d  = 1'b1;
          retry_d = 4'd0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_FAIL: begin
        if (start) do_boot = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_boot) begin
      idx_d   = 4'd0;
      retry_d = 4'd0;
      host_d  = 1'b0;
      done_d  = 1'b0;
      error_d = 1'b0;
      aen_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = S_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      retry_q <= 4'd0;
      cnt_q   <= 24'd0;
      ok_q    <= 1'b0;
      host_q  <= 1'b0;
      haddr_q <= '0;
      hdata_q <= '0;
      reg_q   <= '0;
      din_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      fidx_q  <= 4'd0;
      aen_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      host_q  <= host_d;
      haddr_q <= haddr_d;
      hdata_q <= hdata_d;
      reg_q   <= reg_d;
      din_q   <= din_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      fidx_q  <= fidx_d;
      aen_q   <= aen_d;
      ack_q   <= ack_d;
    end
  end

  assign i2c.i2c_register = reg_q;
  assign i2c.i2c_din      = din_q;
  assign i2c.i2c_enable   = en_q;
  assign i2c.i2c_rw       = 1'b0;
  assign host_ack         = ack_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign fail_index       = fidx_q;
  assign audio_en         = aen_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb/tb_codec_cfg_sequencer.sv - directed bench for codec_cfg_sequencer
module tb_codec_cfg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       host_req;
  logic [6:0] host_addr;
  logic [8:0] host_data;
  logic       host_ack, busy, done, error, audio_en;
  logic [3:0] fail_index;

  codec_cfg_sequencer_if bus();

  codec_cfg_sequencer #(
    .ACT_DELAY      (24'd100),
    .GAP_CYCLES     (16'd4),
    .MAX_RETRY      (2),
    .TIMEOUT_CYCLES (20'd50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .i2c        (bus),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .fail_index (fail_index),
    .audio_en   (audio_en)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // I2C master model: mode 0 good, 1 err on first attempt of R0,
  // 2 err always on R1, 3 never answers. Answers ~40 cycles after enable.
  int         mode = 0;
  int         cyc  = 0;
  logic [6:0] addr_log [128];
  logic [8:0] data_log [128];
  int         t_rise   [128];
  int         t_fall   [128];
  int         n_log    = 0;
  int         ans_cnt  = 0;
  int         ack_cnt  = 0;
  logic       en_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.i2c_enable === 1'b1 && !en_prev && n_log < 128) begin
      addr_log[n_log] = bus.i2c_register;
      data_log[n_log] = bus.i2c_din;
      t_rise[n_log]   = cyc;
      n_log           = n_log + 1;
      ans_cnt         = 0;
    end
    if (bus.i2c_enable !== 1'b1 && en_prev && n_log > 0) t_fall[n_log-1] = cyc;
    if (bus.i2c_enable !== 1'b1) begin
      bus.i2c_rdy = 1'b0;
      bus.i2c_err = 1'b0;
    end else begin
      ans_cnt++;
      if (ans_cnt == 40 && mode != 3) begin
        if ((mode == 2 && bus.i2c_register == 7'd1) ||
            (mode == 1 && bus.i2c_register == 7'd0 &&
             (n_log < 2 || addr_log[n_log-2] != 7'd0)))
          bus.i2c_err = 1'b1;
        else
          bus.i2c_rdy = 1'b1;
      end
    end
    en_prev = (bus.i2c_enable === 1'b1);
    if (host_ack === 1'b1) ack_cnt++;
  end

  logic [6:0] exp_addr [7] = '{7'd15, 7'd6, 7'd0, 7'd1, 7'd4, 7'd7, 7'd9};
  logic [8:0] exp_data [7] = '{9'h000, 9'h000, 9'h017, 9'h017, 9'h002, 9'h04A, 9'h001};
  logic [6:0] exp_retry [8] = '{7'd15, 7'd6, 7'd0, 7'd0, 7'd1, 7'd4, 7'd7, 7'd9};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_done_in_time"}, k < 3000, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_idle_in_time"}, k < 3000, 1);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [8:0] d, input string tag);
    int k = 0;
    host_addr = a;
    host_data = d;
    host_req  = 1'b1;
    while (host_ack !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_ack_in_time"}, k < 3000, 1);
    host_req = 1'b0;
  endtask

  int base, ack_base, r1_cnt, k;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; host_req = 1'b0; host_addr = '0; host_data = '0;
    tick(3);
    check_val("rst_enable",     bus.i2c_enable, 0);
    check_val("rst_register",   bus.i2c_register, 0);
    check_val("rst_din",        bus.i2c_din, 0);
    check_val("rst_rw",         bus.i2c_rw, 0);
    check_val("rst_busy",       busy, 0);
    check_val("rst_done",       done, 0);
    check_val("rst_error",      error, 0);
    check_val("rst_fail_index", fail_index, 0);
    check_val("rst_audio_en",   audio_en, 0);
    check_val("rst_host_ack",   host_ack, 0);

    // Automatic boot after reset, host request raised mid-boot.
    base = n_log; ack_base = ack_cnt;
    reset = 1'b0;
    tick(100);
    check_val("boot1_busy_mid", busy, 1);
    check_val("boot1_done_mid", done, 0);
    host_write(7'd4, 9'h010, "boot1_host");
    check_val("boot1_done_at_ack", done, 1);
    check_val("boot1_audio_en", audio_en, 1);
    check_val("boot1_writes", n_log - base, 8);
    for (int i = 0; i < 7; i++) begin
      check_val($sformatf("boot1_addr%0d", i), addr_log[base+i], exp_addr[i]);
      check_val($sformatf("boot1_data%0d", i), data_log[base+i], exp_data[i]);
    end
    check_val("boot1_act_gap", (t_rise[base+6] - t_fall[base+5]) >= 100, 1);
    check_val("boot1_host_addr", addr_log[base+7], 7'd4);
    check_val("boot1_host_data", data_log[base+7], 9'h010);
    tick(5);
    check_val("boot1_ack_pulses", ack_cnt - ack_base, 1);
    check_val("boot1_busy_end", busy, 0);
    check_val("boot1_error", error, 0);

    // One NACK on index 2, recovered by retry.
    mode = 1; base = n_log;
    do_start();
    wait_done("retry");
    check_val("retry_writes", n_log - base, 8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("retry_addr%0d", i), addr_log[base+i], exp_retry[i]);
    check_val("retry_error", error, 0);
    check_val("retry_audio_en", audio_en, 1);

    // Persistent NACK on index 3 exhausts retries.
    mode = 2; base = n_log;
    do_start();
    wait_idle("fail3");
    r1_cnt = 0;
    for (int i = 0; i < 6; i++) if (addr_log[base+i] == 7'd1) r1_cnt++;
    check_val("fail3_writes", n_log - base, 6);
    check_val("fail3_r1_attempts", r1_cnt, 3);
    check_val("fail3_error", error, 1);
    check_val("fail3_fail_index", fail_index, 3);
    check_val("fail3_busy", busy, 0);
    check_val("fail3_audio_en", audio_en, 0);
    check_val("fail3_done", done, 0);
    mode = 0;
    do_start();
    wait_done("recover3");
    check_val("recover3_error", error, 0);
    check_val("recover3_audio_en", audio_en, 1);

    // Silent master: every attempt times out after exactly 50 cycles.
    mode = 3; base = n_log;
    do_start();
    wait_idle("tmo");
    check_val("tmo_writes", n_log - base, 3);
    for (int i = 0; i < 3; i++)
      check_val($sformatf("tmo_enable_len%0d", i), t_fall[base+i] - t_rise[base+i], 50);
    check_val("tmo_fail_index", fail_index, 0);
    check_val("tmo_error", error, 1);
    check_val("tmo_audio_en", audio_en, 0);
    mode = 0;
    do_start();
    wait_done("recover_tmo");

    // Host writes after boot, including audio_en control through R9.
    base = n_log; ack_base = ack_cnt;
    host_write(7'd4, 9'h010, "host_r4");
    tick(5);
    check_val("host_r4_writes", n_log - base, 1);
    check_val("host_r4_addr", addr_log[base], 7'd4);
    check_val("host_r4_data", data_log[base], 9'h010);
    check_val("host_r4_ack_pulses", ack_cnt - ack_base, 1);
    host_write(7'd9, 9'h000, "host_r9_off");
    check_val("host_r9_off_audio_en", audio_en, 0);
    tick(2);
    host_write(7'd9, 9'h001, "host_r9_on");
    check_val("host_r9_on_audio_en", audio_en, 1);
    check_val("host_error", error, 0);

    // Reset while a transaction is waiting.
    do_start();
    k = 0;
    while (bus.i2c_enable !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("rstw_enable_seen", k < 200, 1);
    tick(10);
    reset = 1'b1;
    @(negedge clk);
    check_val("rstw_enable", bus.i2c_enable, 0);
    check_val("rstw_busy", busy, 0);
    check_val("rstw_done", done, 0);
    check_val("rstw_audio_en", audio_en, 0);
    tick(2);
    base = n_log;
    reset = 1'b0;
    wait_done("rstw");
    check_val("rstw_writes", n_log - base, 7);
    check_val("rstw_first_addr", addr_log[base], 7'd15);
    check_val("rstw_audio_en_end", audio_en, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
